// File: rtl/channel_addr_count_if.sv
// Register-programming and transfer-step bus for one DMA address/count channel.
// Signal names match the legacy port names so existing connections map one-to-one.
interface channel_addr_count_if;
    logic [7:0]  data_in;
    logic        wr_addr;
    logic        wr_count;
    logic        clear_ff;
    logic        auto_init;
    logic        addr_dec;
    logic        step;
    logic [15:0] currentAddress_out;
    logic [15:0] currentWordCount_out;
    logic        terminal_count;
    logic        done;
    logic        byte_ff;

    // Controller side: drives strobes/modes, observes channel state
    modport master (
        output data_in, wr_addr, wr_count, clear_ff, auto_init, addr_dec, step,
        input  currentAddress_out, currentWordCount_out, terminal_count, done, byte_ff
    );

    // Channel side
    modport slave (
        input  data_in, wr_addr, wr_count, clear_ff, auto_init, addr_dec, step,
        output currentAddress_out, currentWordCount_out, terminal_count, done, byte_ff
    );
endinterface

// File: rtl/channel_addr_count.sv
// DMA channel address/word-count registers: byte-wise CPU programming through a
// shared byte pointer, per-transfer address/count update, terminal count with
// optional auto-initialisation from the base registers.
module channel_addr_count #(
    parameter logic [15:0] RESET_ADDR  = 16'h0000,
    parameter logic [15:0] RESET_COUNT = 16'h0000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    channel_addr_count_if.slave  bus
);

    logic [15:0] base_addr_q, base_addr_d;
    logic [15:0] base_cnt_q,  base_cnt_d;
    logic [15:0] cur_addr_q,  cur_addr_d;
    logic [15:0] cur_cnt_q,   cur_cnt_d;
    logic        byte_ff_q,   byte_ff_d;
    logic        done_q,      done_d;
    logic        tc_q,        tc_d;
    logic        cpu_wr;

    assign cpu_wr = bus.wr_addr | bus.wr_count;

    // Next-state: CPU writes take priority; a step is only honoured on a cycle
    // with no write strobe and while the channel is not done.
    always_comb begin
        base_addr_d = base_addr_q;
        base_cnt_d  = base_cnt_q;
        cur_addr_d  = cur_addr_q;
        cur_cnt_d   = cur_cnt_q;
        byte_ff_d   = byte_ff_q;
        done_d      = done_q;
        tc_d        = 1'b0;

        if (bus.clear_ff) begin
            // clear_ff wins over a simultaneous write; the write is discarded
            byte_ff_d = 1'b0;
        end else if (cpu_wr) begin
            if (bus.wr_addr) begin
                if (byte_ff_q) begin
                    base_addr_d[15:8] = bus.data_in;
                    cur_addr_d[15:8]  = bus.data_in;
                end else begin
                    base_addr_d[7:0] = bus.data_in;
                    cur_addr_d[7:0]  = bus.data_in;
                end
            end
            if (bus.wr_count) begin
                if (byte_ff_q) begin
                    base_cnt_d[15:8] = bus.data_in;
                    cur_cnt_d[15:8]  = bus.data_in;
                end else begin
                    base_cnt_d[7:0] = bus.data_in;
                    cur_cnt_d[7:0]  = bus.data_in;
                end
                done_d = 1'b0;
            end
            byte_ff_d = ~byte_ff_q;
        end

        if (bus.step && !done_q && !cpu_wr) begin
            if (cur_cnt_q == '0) begin
                tc_d = 1'b1;
                if (bus.auto_init) begin
                    cur_addr_d = base_addr_q;
                    cur_cnt_d  = base_cnt_q;
                end else begin
                    cur_addr_d = bus.addr_dec ? cur_addr_q - 16'd1 : cur_addr_q + 16'd1;
                    cur_cnt_d  = cur_cnt_q - 16'd1;
                    done_d     = 1'b1;
                end
            end else begin
                cur_addr_d = bus.addr_dec ? cur_addr_q - 16'd1 : cur_addr_q + 16'd1;
                cur_cnt_d  = cur_cnt_q - 16'd1;
            end
        end
    end

    // State registers with synchronous reset overriding every strobe
    always_ff @(posedge CLK) begin
        if (RESET) begin
            base_addr_q <= RESET_ADDR;
            base_cnt_q  <= RESET_COUNT;
            cur_addr_q  <= RESET_ADDR;
            cur_cnt_q   <= RESET_COUNT;
            byte_ff_q   <= 1'b0;
            done_q      <= 1'b0;
            tc_q        <= 1'b0;
        end else begin
            base_addr_q <= base_addr_d;
            base_cnt_q  <= base_cnt_d;
            cur_addr_q  <= cur_addr_d;
            cur_cnt_q   <= cur_cnt_d;
            byte_ff_q   <= byte_ff_d;
            done_q      <= done_d;
            tc_q        <= tc_d;
        end
    end

    assign bus.currentAddress_out   = cur_addr_q;
    assign bus.currentWordCount_out = cur_cnt_q;
    assign bus.terminal_count       = tc_q;
    assign bus.done                 = done_q;
    assign bus.byte_ff              = byte_ff_q;

endmodule

// File: tb/tb_channel_addr_count.sv
// Self-checking bench for channel_addr_count: directed scenarios against fixed
// values plus randomized traffic against a behavioural model of the channel.
module tb_channel_addr_count;

    localparam logic [15:0] RA = 16'hA5C3;
    localparam logic [15:0] RC = 16'h0003;

    logic clk;
    logic rst;
    channel_addr_count_if bus();

    channel_addr_count #(.RESET_ADDR(RA), .RESET_COUNT(RC)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the channel state
    int m_base_a, m_base_c, m_cur_a, m_cur_c;
    int m_bff, m_done, m_tc;

    // Apply one clock cycle of stimulus and advance the model; outputs are
    // sampled by callers 1 time unit after the edge.
    task automatic cyc(input bit r, input logic [7:0] d, input bit wa, input bit wc,
                       input bit cf, input bit ai, input bit ad, input bit st);
        int old_done, wr, lane;
        rst = r;
        bus.data_in = d; bus.wr_addr = wa; bus.wr_count = wc; bus.clear_ff = cf;
        bus.auto_init = ai; bus.addr_dec = ad; bus.step = st;
        @(posedge clk);
        m_tc = 0;
        if (r) begin
            m_base_a = RA; m_cur_a = RA; m_base_c = RC; m_cur_c = RC;
            m_bff = 0; m_done = 0;
        end else begin
            old_done = m_done;
            wr = (wa || wc) ? 1 : 0;
            if (cf) begin
                m_bff = 0;
            end else if (wr) begin
                lane = m_bff;
                if (wa) begin
                    if (lane == 0) m_base_a = (m_base_a / 256) * 256 + d;
                    else           m_base_a = (m_base_a % 256) + d * 256;
                    if (lane == 0) m_cur_a = (m_cur_a / 256) * 256 + d;
                    else           m_cur_a = (m_cur_a % 256) + d * 256;
                end
                if (wc) begin
                    if (lane == 0) m_base_c = (m_base_c / 256) * 256 + d;
                    else           m_base_c = (m_base_c % 256) + d * 256;
                    if (lane == 0) m_cur_c = (m_cur_c / 256) * 256 + d;
                    else           m_cur_c = (m_cur_c % 256) + d * 256;
                    m_done = 0;
                end
                m_bff = 1 - m_bff;
            end
            if (st && old_done == 0 && wr == 0) begin
                if (m_cur_c == 0 && ai) begin
                    m_tc = 1;
                    m_cur_a = m_base_a;
                    m_cur_c = m_base_c;
                end else begin
                    if (m_cur_c == 0) begin
                        m_tc = 1;
                        m_done = 1;
                    end
                    m_cur_a = ad ? (m_cur_a + 65535) % 65536 : (m_cur_a + 1) % 65536;
                    m_cur_c = (m_cur_c + 65535) % 65536;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit ai, input bit ad);
        cyc(0, 8'h00, 0, 0, 0, ai, ad, 0);
    endtask

    task automatic program_ch(input logic [15:0] a, input logic [15:0] c);
        cyc(0, 8'h00, 0, 0, 1, 0, 0, 0);
        cyc(0, a[7:0],  1, 0, 0, 0, 0, 0);
        cyc(0, a[15:8], 1, 0, 0, 0, 0, 0);
        cyc(0, c[7:0],  0, 1, 0, 0, 0, 0);
        cyc(0, c[15:8], 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cyc(1, 8'hFF, 1, 1, 0, 1, 1, 1);
        cyc(1, 8'hFF, 1, 1, 0, 1, 1, 1);
        checks++; if (bus.currentAddress_out !== RA) begin errors++;
            $display("FAIL reset_addr got %h want %h", bus.currentAddress_out, RA); end
        checks++; if (bus.currentWordCount_out !== RC) begin errors++;
            $display("FAIL reset_count got %h want %h", bus.currentWordCount_out, RC); end
        checks++; if ({bus.byte_ff, bus.done, bus.terminal_count} !== 3'b000) begin errors++;
            $display("FAIL reset_flags got %b want 000", {bus.byte_ff, bus.done, bus.terminal_count}); end
    endtask

    task automatic test_program();
        program_ch(16'h1234, 16'h0002);
        checks++; if (bus.currentAddress_out !== 16'h1234) begin errors++;
            $display("FAIL prog_addr got %h want 1234", bus.currentAddress_out); end
        checks++; if (bus.currentWordCount_out !== 16'h0002) begin errors++;
            $display("FAIL prog_count got %h want 0002", bus.currentWordCount_out); end
        checks++; if (bus.byte_ff !== 1'b0) begin errors++;
            $display("FAIL prog_byteff got %b want 0", bus.byte_ff); end
    endtask

    task automatic test_countdown();
        logic [15:0] exp_cnt [3] = '{16'h0001, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 0, 0, 0, 0, 0, 1);
            checks++; if (bus.currentWordCount_out !== exp_cnt[i]) begin errors++;
                $display("FAIL cd_count%0d got %h want %h", i, bus.currentWordCount_out, exp_cnt[i]); end
            checks++; if (bus.terminal_count !== (i == 2)) begin errors++;
                $display("FAIL cd_tc%0d got %b want %b", i, bus.terminal_count, (i == 2)); end
        end
        checks++; if (bus.currentAddress_out !== 16'h1237) begin errors++;
            $display("FAIL cd_addr got %h want 1237", bus.currentAddress_out); end
        checks++; if (bus.done !== 1'b1) begin errors++;
            $display("FAIL cd_done got %b want 1", bus.done); end
        cyc(0, 8'h00, 0, 0, 0, 0, 0, 1);
        checks++; if ({bus.currentAddress_out, bus.currentWordCount_out, bus.terminal_count} !== {16'h1237, 16'hFFFF, 1'b0}) begin errors++;
            $display("FAIL cd_after_done got %h %h %b want 1237 ffff 0", bus.currentAddress_out, bus.currentWordCount_out, bus.terminal_count); end
    endtask

    task automatic test_autoinit();
        int pulses = 0;
        program_ch(16'h1234, 16'h0002);
        checks++; if (bus.done !== 1'b0) begin errors++;
            $display("FAIL ai_done_cleared got %b want 0", bus.done); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 0, 0, 0, 1, 0, 1);
            if (bus.terminal_count === 1'b1) pulses++;
        end
        idle(1, 0);
        if (bus.terminal_count === 1'b1) pulses++;
        checks++; if ({bus.currentAddress_out, bus.currentWordCount_out, bus.done} !== {16'h1234, 16'h0002, 1'b0}) begin errors++;
            $display("FAIL ai_state got %h %h %b want 1234 0002 0", bus.currentAddress_out, bus.currentWordCount_out, bus.done); end
        checks++; if (pulses != 1) begin errors++;
            $display("FAIL ai_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_wrap();
        program_ch(16'h0000, 16'h0010);
        cyc(0, 8'h00, 0, 0, 0, 0, 1, 1);
        checks++; if (bus.currentAddress_out !== 16'hFFFF) begin errors++;
            $display("FAIL wrap_dec got %h want ffff", bus.currentAddress_out); end
        cyc(0, 8'h00, 0, 0, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 0, 0, 1);
        checks++; if (bus.currentAddress_out !== 16'h0001) begin errors++;
            $display("FAIL wrap_inc got %h want 0001", bus.currentAddress_out); end
    endtask

    task automatic test_collision();
        program_ch(16'h1234, 16'h0002);
        cyc(0, 8'h05, 0, 1, 0, 0, 0, 1);
        checks++; if ({bus.currentWordCount_out, bus.currentAddress_out, bus.byte_ff} !== {16'h0005, 16'h1234, 1'b1}) begin errors++;
            $display("FAIL coll_step got %h %h %b want 0005 1234 1", bus.currentWordCount_out, bus.currentAddress_out, bus.byte_ff); end
        cyc(0, 8'h77, 1, 0, 1, 0, 0, 0);
        checks++; if ({bus.currentAddress_out, bus.byte_ff} !== {16'h1234, 1'b0}) begin errors++;
            $display("FAIL coll_clear got %h %b want 1234 0", bus.currentAddress_out, bus.byte_ff); end
    endtask

    task automatic test_reset_mid();
        program_ch(16'h1234, 16'h0002);
        cyc(0, 8'h00, 0, 0, 0, 0, 0, 1);
        cyc(1, 8'h00, 0, 0, 0, 0, 0, 1);
        checks++; if ({bus.currentAddress_out, bus.currentWordCount_out, bus.byte_ff, bus.done, bus.terminal_count} !== {RA, RC, 3'b000}) begin errors++;
            $display("FAIL rstmid got %h %h %b%b%b want %h %h 000", bus.currentAddress_out, bus.currentWordCount_out, bus.byte_ff, bus.done, bus.terminal_count, RA, RC); end
        // Reset landing on a would-be terminal count must suppress the pulse
        program_ch(16'h4000, 16'h0000);
        cyc(1, 8'h00, 0, 0, 0, 0, 0, 1);
        checks++; if ({bus.terminal_count, bus.done} !== 2'b00) begin errors++;
            $display("FAIL rst_tc got %b%b want 00", bus.terminal_count, bus.done); end
        idle(0, 0);
        checks++; if (bus.terminal_count !== 1'b0) begin errors++;
            $display("FAIL rst_tc_late got %b want 0", bus.terminal_count); end
    endtask

    task automatic test_random();
        bit r, wa, wc, cf, ai, ad, st;
        logic [7:0] d;
        program_ch(16'h8000, 16'h0004);
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 99) < 2);
            wa = ($urandom_range(0, 99) < 10);
            wc = ($urandom_range(0, 99) < 8);
            cf = ($urandom_range(0, 99) < 5);
            ai = ($urandom_range(0, 1) == 1);
            ad = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 99) < 60);
            d  = 8'($urandom_range(0, 255));
            if (cf && (wa || wc)) st = 0;
            cyc(r, d, wa, wc, cf, ai, ad, st);
            checks++;
            if (bus.currentAddress_out !== 16'(m_cur_a) || bus.currentWordCount_out !== 16'(m_cur_c) ||
                bus.byte_ff !== 1'(m_bff) || bus.done !== 1'(m_done) || bus.terminal_count !== 1'(m_tc)) begin
                errors++;
                $display("FAIL rand%0d got a=%h c=%h bff=%b done=%b tc=%b want a=%h c=%h bff=%0d done=%0d tc=%0d",
                         n, bus.currentAddress_out, bus.currentWordCount_out, bus.byte_ff, bus.done,
                         bus.terminal_count, 16'(m_cur_a), 16'(m_cur_c), m_bff, m_done, m_tc);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.data_in = '0; bus.wr_addr = 0; bus.wr_count = 0; bus.clear_ff = 0;
        bus.auto_init = 0; bus.addr_dec = 0; bus.step = 0;
        m_base_a = RA; m_cur_a = RA; m_base_c = RC; m_cur_c = RC;
        m_bff = 0; m_done = 0; m_tc = 0;
        #1;
        test_reset();
        test_program();
        test_countdown();
        test_autoinit();
        test_wrap();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
